// File: rtl/data_mem_ctrl.sv
// Data-memory controller between the pipeline memory stage and a word-wide memory.
// It replicates store data into byte lanes, formats loads, and bounds each access with a timeout.
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    // Unsupported size codes behave as a full word.
    function automatic logic [2:0] norm_f3(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_BU, F3_HU: return f3;
            default:                  return F3_W;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return w;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [2:0]        f3_in;
    logic              req_any;
    logic              misaligned;

    assign f3_in   = norm_f3(funct3);
    assign req_any = rd_en | wr_en;

    always_comb begin
        case (f3_in[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d    = state_q;
        f3_d       = f3_q;
        off_d      = off_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        mem_req    = 1'b0;
        stall      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        // A simultaneous load and store resolves to the store.
                        stall   = 1'b1;
                        state_d = ACCESS;
                        f3_d    = f3_in;
                        off_d   = addr[1:0];
                        we_d    = wr_en;
                        addr_d  = {addr[31:2], 2'b00};
                        wdata_d = lane_data(f3_in, wdata);
                        be_d    = lane_be(f3_in, addr[1:0]);
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack) begin
                    if (!we_q) rdata_d = fmt_load(f3_q, off_q, mem_rdata);
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            f3_q       <= F3_B;
            off_q      <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_be      = be_q;
    assign rdata       = rdata_q;
    assign misalign    = misalign_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: hand-computed vectors for loads, stores,
// misalignment, timeout and reset abort.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        timeout_err;

    int vectors     = 0;
    int miscompares = 0;
    int stall_cnt;
    int req_cnt;

    data_mem_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .rdata      (rdata),
        .stall      (stall),
        .misalign   (misalign),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
        rd_en = 1'b1; funct3 = f3; addr = a;
        #1 check({tag, "_stall_req"}, 32'(stall), 32'd1);
        tick;
        rd_en = 1'b0; mem_ack = 1'b1; mem_rdata = word;
        #1 check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        tick;
        mem_ack = 1'b0; mem_rdata = '0;
        #1 check({tag, "_rdata"}, rdata, exp);
        check({tag, "_done_stall"}, 32'(stall), 32'd0);
        tick;
    endtask

    task automatic do_store(input string tag, input logic both, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic [31:0] keep_rdata);
        wr_en = 1'b1; rd_en = both; funct3 = f3; addr = a; wdata = d;
        tick;
        wr_en = 1'b0; rd_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1 check({tag, "_we"}, 32'(mem_we), 32'd1);
        check({tag, "_be"}, 32'(mem_be), 32'(exp_be));
        check({tag, "_wdata"}, mem_wdata, exp_wd);
        check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        tick;
        mem_ack = 1'b0; mem_rdata = '0;
        #1 check({tag, "_rdata_kept"}, rdata, keep_rdata);
        tick;
    endtask

    task automatic do_misalign(input string tag, input logic f3_wr, input logic [2:0] f3,
                               input logic [31:0] a);
        rd_en = ~f3_wr; wr_en = f3_wr; funct3 = f3; addr = a;
        #1 check({tag, "_stall"}, 32'(stall), 32'd0);
        tick;
        rd_en = 1'b0; wr_en = 1'b0;
        #1 check({tag, "_pulse"}, 32'(misalign), 32'd1);
        check({tag, "_no_req"}, 32'(mem_req), 32'd0);
        tick;
        #1 check({tag, "_pulse_end"}, 32'(misalign), 32'd0);
        check({tag, "_no_req2"}, 32'(mem_req), 32'd0);
        tick;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; funct3 = 3'b000; addr = '0;
        wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        tick; tick;
        #1 check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick;

        // LB 0x103, ack on the third request cycle
        stall_cnt = 0;
        rd_en = 1'b1; funct3 = 3'b000; addr = 32'h103;
        #1 stall_cnt += int'(stall);
        check("lb_idle_no_req", 32'(mem_req), 32'd0);
        tick;
        rd_en = 1'b0;
        #1 stall_cnt += int'(stall);
        check("lb_req", 32'(mem_req), 32'd1);
        check("lb_addr", mem_addr, 32'h100);
        check("lb_be", 32'(mem_be), 32'h8);
        check("lb_we", 32'(mem_we), 32'd0);
        tick;
        #1 stall_cnt += int'(stall);
        check("lb_req_held", 32'(mem_req), 32'd1);
        tick;
        mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
        #1 stall_cnt += int'(stall);
        tick;
        // DONE: requests and stray acks are ignored
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678; rd_en = 1'b1;
        #1 stall_cnt += int'(stall);
        check("lb_stall_cycles", 32'(stall_cnt), 32'd4);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        check("lb_done_req", 32'(mem_req), 32'd0);
        tick;
        mem_ack = 1'b0; mem_rdata = '0; rd_en = 1'b0;
        #1 check("lb_rdata_after_done", rdata, 32'hFFFF_FF80);
        check("lb_done_rd_ignored", 32'(mem_req), 32'd0);
        tick;

        // SH 0x22 with immediate ack: two stall cycles
        stall_cnt = 0;
        wr_en = 1'b1; funct3 = 3'b001; addr = 32'h22; wdata = 32'h1234_ABCD;
        #1 stall_cnt += int'(stall);
        tick;
        wr_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1 stall_cnt += int'(stall);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        check("sh_be", 32'(mem_be), 32'hC);
        check("sh_we", 32'(mem_we), 32'd1);
        tick;
        mem_ack = 1'b0;
        #1 stall_cnt += int'(stall);
        check("sh_stall_cycles", 32'(stall_cnt), 32'd2);
        check("sh_rdata_kept", rdata, 32'hFFFF_FF80);
        tick;

        // Misaligned accesses
        do_misalign("lw_41", 1'b0, 3'b010, 32'h41);
        do_misalign("lh_3", 1'b0, 3'b001, 32'h3);
        do_misalign("sw011_2", 1'b1, 3'b011, 32'h2);

        // Load formatting
        do_load("lh_6", 3'b001, 32'h6, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("lhu_4", 3'b101, 32'h4, 32'h8001_F00D, 32'h0000_F00D);
        do_load("lbu_1", 3'b100, 32'h1, 32'h0000_9A00, 32'h0000_009A);
        do_load("lb_2", 3'b000, 32'h2, 32'h007F_0000, 32'h0000_007F);
        do_load("lw_c", 3'b010, 32'hC, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Store lane encoding, store priority, unsupported size code
        do_store("sb_3", 1'b0, 3'b000, 32'h3, 32'h1234_565A, 4'b1000, 32'h5A5A_5A5A, 32'hCAFE_F00D);
        do_store("sw_both", 1'b1, 3'b010, 32'h8, 32'h55AA_33CC, 4'b1111, 32'h55AA_33CC, 32'hCAFE_F00D);
        do_store("sw_f3_111", 1'b0, 3'b111, 32'h14, 32'h0BAD_CAFE, 4'b1111, 32'h0BAD_CAFE, 32'hCAFE_F00D);
        do_store("sh_0", 1'b0, 3'b001, 32'h0, 32'h0000_7E81, 4'b0011, 32'h7E81_7E81, 32'hCAFE_F00D);

        // LHU 0x2 with no ack: timeout after 16 request cycles
        req_cnt = 0;
        rd_en = 1'b1; funct3 = 3'b101; addr = 32'h2;
        tick;
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1 req_cnt += int'(mem_req);
            if (i == 0) check("to_be", 32'(mem_be), 32'hC);
            if (i == 15) check("to_not_yet", 32'(timeout_err), 32'd0);
            tick;
        end
        #1 check("to_req_cycles", 32'(req_cnt), 32'd16);
        check("to_flag", 32'(timeout_err), 32'd1);
        check("to_rdata", rdata, 32'd0);
        check("to_done_stall", 32'(stall), 32'd0);
        check("to_done_req", 32'(mem_req), 32'd0);
        tick;
        #1 check("to_idle_req", 32'(mem_req), 32'd0);
        tick;
        do_load("lw_20", 3'b010, 32'h20, 32'h1111_1111, 32'h1111_1111);
        #1 check("to_sticky", 32'(timeout_err), 32'd1);
        tick;

        // Reset in the middle of a store, then a late ack
        wr_en = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'hA5A5_A5A5;
        tick;
        wr_en = 1'b0;
        tick;
        rst = 1'b1;
        #1 check("ra_pre_req", 32'(mem_req), 32'd1);
        tick;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1 check("ra_req", 32'(mem_req), 32'd0);
        check("ra_stall", 32'(stall), 32'd0);
        check("ra_we", 32'(mem_we), 32'd0);
        check("ra_addr", mem_addr, 32'd0);
        check("ra_wdata", mem_wdata, 32'd0);
        check("ra_be", 32'(mem_be), 32'd0);
        check("ra_rdata", rdata, 32'd0);
        check("ra_timeout", 32'(timeout_err), 32'd0);
        check("ra_misalign", 32'(misalign), 32'd0);
        tick;
        mem_ack = 1'b0; mem_rdata = '0;
        #1 check("ra_late_ack_rdata", rdata, 32'd0);
        check("ra_late_ack_req", 32'(mem_req), 32'd0);
        check("ra_late_ack_stall", 32'(stall), 32'd0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max cycles in ACCESS waiting for mem_ack.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rd_en  input  1  load request from pipeline memory stage.
REQ-005 SHALL have port wr_en  input  1  store request from pipeline memory stage.
REQ-006 SHALL have port funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  store data, LSB-justified.
REQ-009 SHALL have port mem_ack  input  1  memory completion, single-cycle pulse.
REQ-010 SHALL have port mem_rdata  input  32  memory read word, valid with mem_ack.
REQ-011 SHALL have port mem_req  output  1  memory request, held until ack or timeout.
REQ-012 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-013 SHALL have port mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-014 SHALL have port mem_wdata  output  32  lane-replicated store data.
REQ-015 SHALL have port mem_be  output  4  byte enables.
REQ-016 SHALL have port rdata  output  32  aligned, extended load result.
REQ-017 SHALL have port stall  output  1  freeze pipeline while access is pending.
REQ-018 SHALL have port misalign  output  1  one-cycle pulse on misaligned access.
REQ-019 SHALL have port timeout_err  output  1  sticky flag, set on timeout.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-021 IDLE, (rd_en|wr_en) and aligned: latch addr/funct3/wdata/op, go ACCESS; stall=1 combinationally in that same cycle.
REQ-022 IDLE, request misaligned (H with addr[0]=1; W with addr[1:0]!=0): misalign=1 next cycle for one cycle, no mem_req, stall=0, stay IDLE.
REQ-023 rd_en and wr_en both high: store SHALL win.
REQ-024 Unsupported funct3 (011, 110, 111): SHALL be treated as 010.
REQ-025 ACCESS: mem_req=1, stall=1; mem_we/addr/wdata/be stable from latched values until exit.
REQ-026 Store encoding: B gives mem_wdata={4{wdata[7:0]}} and mem_be=0001<<addr[1:0]; H gives {2{wdata[15:0]}} and 0011<<addr[1:0]; W gives wdata and 1111.
REQ-027 Loads: mem_be SHALL equal the store encoding of the same size; mem_wdata is don't-care.
REQ-028 ACCESS with mem_ack=1: register formatted load into rdata, go DONE; mem_req drops the next cycle.
REQ-029 Load format: select byte/half by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passthrough.
REQ-030 Store completion: rdata SHALL be unchanged.
REQ-031 ACCESS cycle counter: on reaching TIMEOUT with no ack, set timeout_err, rdata=0, go DONE.
REQ-032 DONE: stall=0 for exactly one cycle so the pipeline advances; rd_en/wr_en ignored; next state IDLE.
REQ-033 mem_ack in IDLE or DONE SHALL be ignored.
REQ-034 Load-to-DONE latency: 1 + (cycles until ack); minimum is a 2-cycle stall with immediate ack.

Reset
REQ-035 rst=1 at clock edge: state IDLE; mem_req, mem_we, stall, misalign, timeout_err, counter = 0; rdata, mem_addr, mem_wdata = 0; mem_be=0000.
REQ-036 Reset during ACCESS SHALL abort without completion; a later mem_ack SHALL be ignored.

Verification
REQ-037 LB addr=0x103, mem_rdata=0x80FF_0000, ack 3 cycles after req -> mem_addr=0x100, mem_be=1000, stall high 4 cycles, rdata=0xFFFF_FF80.
REQ-038 SH addr=0x22, wdata=0x1234_ABCD, immediate ack -> mem_wdata=0xABCD_ABCD, mem_be=1100, mem_we=1, stall 2 cycles.
REQ-039 LW addr=0x41 -> misalign pulse 1 cycle, mem_req never asserted, stall=0.
REQ-040 LHU addr=0x2, no ack, TIMEOUT=16 -> timeout_err=1 after 16 ACCESS cycles, rdata=0, DONE then IDLE.
REQ-041 rst asserted mid-ACCESS, ack arrives after reset -> all outputs 0, state IDLE, rdata unchanged at 0.
REQ-042 rd_en=wr_en=1 SW addr=0x8 -> store issued (mem_we=1, mem_be=1111).
